truth_table_sweeper: RTL

TRUTH_TABLE_SWEEPER -- requirements
Module: truth_table_sweeper

---
 rtl/tt_sweep_pkg.sv | 25 ++
 rtl/tt_sweep_voter.sv | 56 +++++
 rtl/truth_table_sweeper.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/tt_sweep_pkg.sv
// Shared types for the truth-table sweeper: FSM states, row index and table types.
package tt_sweep_pkg;

    localparam int unsigned ROWS = 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DRIVE,
        ST_SAMPLE,
        ST_DONE
    } state_t;

    typedef logic [2:0] row_t;
    typedef logic [7:0] table_t;

    function automatic logic [3:0] popcount8(input table_t v);
        logic [3:0] n;
        n = '0;
        for (int unsigned i = 0; i < ROWS; i++) begin
            n = n + {3'b000, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/tt_sweep_voter.sv
// Majority voter over VOTES consecutive samples of one truth-table row.
// TT_SWEEP_GLITCH_EN adds the all-equal flag used for glitch reporting.
module tt_sweep_voter #(
    parameter int VOTES = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic first,
    input  logic din,
    output logic maj
`ifdef TT_SWEEP_GLITCH_EN
    ,
    output logic all_eq
`endif
);

    logic [3:0] ones_q;
    logic [3:0] ones_now;

    // Results include the sample on the current edge so the row can be written on its last edge.
    always_comb begin
        ones_now = (first ? 4'd0 : ones_q) + {3'b000, din};
        maj      = (ones_now > 4'(VOTES / 2));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ones_q <= '0;
        end else if (en) begin
            ones_q <= ones_now;
        end
    end

`ifdef TT_SWEEP_GLITCH_EN
    logic seen0_q, seen1_q;
    logic seen0_now, seen1_now;

    always_comb begin
        seen0_now = (~first & seen0_q) | ~din;
        seen1_now = (~first & seen1_q) | din;
        all_eq    = ~(seen0_now & seen1_now);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seen0_q <= 1'b0;
            seen1_q <= 1'b0;
        end else if (en) begin
            seen0_q <= seen0_now;
            seen1_q <= seen1_now;
        end
    end
`endif

endmodule

// File: rtl/truth_table_sweeper.sv
// Sweeps a 3-input logic stage through all 8 rows, majority-votes each row and compares
// against an expected table. Define TT_SWEEP_GLITCH_EN to report per-row sample disagreement.
module truth_table_sweeper
    import tt_sweep_pkg::*;
#(
    parameter int SETTLE = 4,
    parameter int VOTES  = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] expected,
    input  logic       dut_out,
    output logic [2:0] in_vec,
    output logic       busy,
    output logic       done,
    output logic [7:0] observed,
    output logic       pass,
    output logic [3:0] mismatch_cnt,
    output logic [7:0] glitch
);

    state_t     state, state_nx;
    logic [7:0] settle_cnt;
    logic [3:0] vote_cnt;
    row_t       row;
    table_t     obs_q;
    logic       pass_q;
    logic [3:0] mm_q;
    logic       maj;
    logic       settle_last, vote_last, row_last;
    logic       sample_en, first_vote;

    assign settle_last = (settle_cnt == 8'(SETTLE - 1));
    assign vote_last   = (vote_cnt == 4'(VOTES - 1));
    assign row_last    = (row == row_t'(ROWS - 1));
    assign sample_en   = (state == ST_SAMPLE);
    assign first_vote  = (vote_cnt == '0);

`ifdef TT_SWEEP_GLITCH_EN
    logic   all_eq;
    table_t glitch_q;
`endif

    tt_sweep_voter #(.VOTES(VOTES)) u_voter (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (sample_en),
        .first (first_vote),
        .din   (dut_out),
        .maj   (maj)
`ifdef TT_SWEEP_GLITCH_EN
        ,
        .all_eq(all_eq)
`endif
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:   if (start) state_nx = ST_DRIVE;
            ST_DRIVE:  if (settle_last) state_nx = ST_SAMPLE;
            ST_SAMPLE: if (vote_last) state_nx = row_last ? ST_DONE : ST_DRIVE;
            ST_DONE:   state_nx = ST_IDLE;
            default:   state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            settle_cnt <= '0;
            vote_cnt   <= '0;
            row        <= '0;
            obs_q      <= '0;
            pass_q     <= 1'b0;
            mm_q       <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        settle_cnt <= '0;
                        vote_cnt   <= '0;
                        row        <= '0;
                        obs_q      <= '0;
                        pass_q     <= 1'b0;
                        mm_q       <= '0;
                    end
                end
                ST_DRIVE: begin
                    settle_cnt <= settle_last ? '0 : settle_cnt + 8'd1;
                end
                ST_SAMPLE: begin
                    vote_cnt <= vote_last ? '0 : vote_cnt + 4'd1;
                    if (vote_last) begin
                        obs_q[row] <= maj;
                        if (!row_last) row <= row + row_t'(1);
                    end
                end
                ST_DONE: begin
                    // Freeze the DONE-cycle comparison so results hold while expected moves.
                    pass_q <= (obs_q == expected);
                    mm_q   <= popcount8(obs_q ^ expected);
                end
                default: ;
            endcase
        end
    end

`ifdef TT_SWEEP_GLITCH_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            glitch_q <= '0;
        end else if (state == ST_IDLE && start) begin
            glitch_q <= '0;
        end else if (state == ST_SAMPLE && vote_last) begin
            glitch_q[row] <= ~all_eq;
        end
    end
`endif

    always_comb begin
        in_vec   = row;
        observed = obs_q;
        busy     = (state == ST_DRIVE) || (state == ST_SAMPLE);
        done     = (state == ST_DONE);
        if (state == ST_DONE) begin
            pass         = (obs_q == expected);
            mismatch_cnt = popcount8(obs_q ^ expected);
        end else begin
            pass         = pass_q;
            mismatch_cnt = mm_q;
        end
`ifdef TT_SWEEP_GLITCH_EN
        glitch = glitch_q;
`else
        glitch = '0;
`endif
    end

endmodule
